// File: rtl/car_scheduler.sv
// Purpose: round-level car spawn scheduler: FSM, LFSR, per-lane gap timers, per-slot life timers, hit summary.
// Latency: spawn, expiry and hit summary appear one FrameClk edge after the frame that decides them.
// Backpressure: none; a lane without a free slot skips its turn, and hits never stall or alter slots.
module car_scheduler #(
   parameter int          NUM_LANES      = 4,
   parameter int          SLOTS_PER_LANE = 2,
   parameter int          GAP_BASE       = 120,
   parameter int          GAP_STEP       = 24,
   parameter logic [9:0]  LANE_Y0        = 10'd96,
   parameter logic [9:0]  LANE_PITCH     = 10'd64,
   parameter bit          RAND_SPAWN     = 1'b1,
   parameter logic [15:0] LFSR_SEED      = 16'hACE1
) (
   input  logic                                   FrameClk,
   input  logic                                   ResetN,
   input  logic                                   RoundActive,
   input  logic [1:0]                             Level,
   input  logic [NUM_LANES*SLOTS_PER_LANE-1:0]    P1HitVec,
   input  logic [NUM_LANES*SLOTS_PER_LANE-1:0]    P2HitVec,
   output logic [NUM_LANES*SLOTS_PER_LANE-1:0]    SpawnEnable,
   output logic [2*NUM_LANES*SLOTS_PER_LANE-1:0]  SlotType,
   output logic [3*NUM_LANES-1:0]                 LaneSpeed,
   output logic [NUM_LANES-1:0]                   LaneFaceLeft,
   output logic [10*NUM_LANES-1:0]                LaneSpawnX,
   output logic [10*NUM_LANES-1:0]                LaneSpawnY,
   output logic                                   P1Hit,
   output logic                                   P2Hit,
   output logic                                   Busy
);
   localparam int NS = NUM_LANES * SLOTS_PER_LANE;
   localparam int PW = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;

   typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2} state_t;

   state_t                          state_q;
   logic [15:0]                     lfsr_q, lfsr_d;
   logic [PW-1:0]                   ptr_q, ptr_d;
   logic [NUM_LANES-1:0][7:0]       gap_q, gap_d;
   logic [NS-1:0][10:0]             life_q, life_d;
   logic [NS-1:0]                   en_q, en_d;
   logic [NS-1:0][1:0]              type_q, type_d;
   logic [NUM_LANES-1:0][2:0]       spd_q, spd_d, spd_new;
   logic                            p1_q, p2_q;
   logic                            claimed;
   logic [7:0]                      gap_load;

   // Frames a car stays on screen for a given lane speed.
   function automatic logic [10:0] life_of(input logic [2:0] spd);
      case (spd)
         3'd1:    life_of = 11'd1376;
         3'd2:    life_of = 11'd688;
         3'd3:    life_of = 11'd460;
         3'd4:    life_of = 11'd344;
         3'd5:    life_of = 11'd276;
         3'd6:    life_of = 11'd230;
         3'd7:    life_of = 11'd198;
         default: life_of = 11'd1376;
      endcase
   endfunction

   assign lfsr_d   = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
   assign gap_load = 8'(GAP_BASE - 32'(Level) * GAP_STEP);

   // Fixed lane geometry plus the speed each lane would take if the round started now.
   for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
      logic [3:0] sum;
      assign sum                      = 4'd1 + 4'(Level) + 4'(lfsr_q[(g + 4) % 16]);
      assign spd_new[g]               = (sum > 4'd7) ? 3'd7 : sum[2:0];
      assign LaneFaceLeft[g]          = 1'(g % 2);
      assign LaneSpawnX[g*10 +: 10]   = (g % 2 == 1) ? 10'd740 : 10'd51;
      assign LaneSpawnY[g*10 +: 10]   = 10'(LANE_Y0 + 10'(g) * LANE_PITCH);
   end

   // Next-state for timers, slots, pointer and speeds.
   always_comb begin
      ptr_d   = ptr_q;
      gap_d   = gap_q;
      life_d  = life_q;
      en_d    = en_q;
      type_d  = type_q;
      spd_d   = spd_q;
      claimed = 1'b0;
      for (int l = 0; l < NUM_LANES; l++) begin
         if (gap_q[l] != 8'd0) gap_d[l] = gap_q[l] - 8'd1;
      end
      // Slots expire in RUN and DRAIN; a slot cleared this edge was still enabled, so it cannot be reclaimed until next frame.
      if (state_q != IDLE) begin
         for (int k = 0; k < NS; k++) begin
            if (en_q[k]) begin
               if (life_q[k] == 11'd1) begin
                  en_d[k]   = 1'b0;
                  life_d[k] = 11'd0;
               end else begin
                  life_d[k] = life_q[k] - 11'd1;
               end
            end
         end
      end
      if (state_q == RUN) begin
         ptr_d = (ptr_q == PW'(NUM_LANES - 1)) ? '0 : ptr_q + 1'b1;
         for (int l = 0; l < NUM_LANES; l++) begin
            if (ptr_q == PW'(l) && gap_q[l] == 8'd0 && (!RAND_SPAWN || lfsr_q[0])) begin
               for (int j = 0; j < SLOTS_PER_LANE; j++) begin
                  if (!claimed && !en_q[l*SLOTS_PER_LANE + j]) begin
                     claimed                        = 1'b1;
                     en_d[l*SLOTS_PER_LANE + j]     = 1'b1;
                     type_d[l*SLOTS_PER_LANE + j]   = lfsr_q[2:1];
                     life_d[l*SLOTS_PER_LANE + j]   = life_of(spd_q[l]);
                     gap_d[l]                       = gap_load;
                  end
               end
            end
         end
      end
      if (state_q == IDLE && RoundActive) spd_d = spd_new;
   end

   // Round FSM; a returning RoundActive in DRAIN wins over going idle.
   always_ff @(posedge FrameClk or negedge ResetN) begin
      if (!ResetN) begin
         state_q <= IDLE;
      end else begin
         case (state_q)
            IDLE:    if (RoundActive) state_q <= RUN;
            RUN:     if (!RoundActive) state_q <= DRAIN;
            DRAIN:   if (RoundActive) state_q <= RUN;
                     else if (en_q == '0) state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

   // Datapath registers; reset drops every slot at once without a drain.
   always_ff @(posedge FrameClk or negedge ResetN) begin
      if (!ResetN) begin
         lfsr_q <= LFSR_SEED;
         ptr_q  <= '0;
         gap_q  <= '0;
         life_q <= '0;
         en_q   <= '0;
         type_q <= '0;
         spd_q  <= '0;
         p1_q   <= 1'b0;
         p2_q   <= 1'b0;
      end else begin
         lfsr_q <= lfsr_d;
         ptr_q  <= ptr_d;
         gap_q  <= gap_d;
         life_q <= life_d;
         en_q   <= en_d;
         type_q <= type_d;
         spd_q  <= spd_d;
         p1_q   <= |(P1HitVec & en_q);
         p2_q   <= |(P2HitVec & en_q);
      end
   end

   assign SpawnEnable = en_q;
   assign SlotType    = type_q;
   assign LaneSpeed   = spd_q;
   assign P1Hit       = p1_q;
   assign P2Hit       = p2_q;
   assign Busy        = (state_q != IDLE);
endmodule

// File: tb/tb_car_scheduler.sv
// Bench for car_scheduler: a deterministic and a random-spawn instance share stimulus.
// A frame-level reference model predicts every output; predictions queue at drive time and pop after the edge.
// Hand sequences cover spawn order, gap, life length, drain and asynchronous reset.
module tb_car_scheduler;
   localparam logic [1:0] S_IDLE = 2'd0, S_RUN = 2'd1, S_DRAIN = 2'd2;

   typedef struct packed {
      logic [1:0]        st;
      logic [15:0]       lfsr;
      logic [1:0]        ptr;
      logic [3:0][7:0]   gap;
      logic [7:0][10:0]  life;
      logic [7:0]        en;
      logic [7:0][1:0]   typ;
      logic [3:0][2:0]   spd;
      logic              p1;
      logic              p2;
   } mstate_t;

   typedef struct { int lane; logic face; logic [9:0] x; logic [9:0] y; } lane_vec_t;
   typedef struct { bit rst; bit ra; logic [1:0] lv; bit rndhit; int frames; } phase_t;

   logic        FrameClk, ResetN, RoundActive;
   logic [1:0]  Level;
   logic [7:0]  P1HitVec, P2HitVec;
   logic [7:0]  det_en, rnd_en;
   logic [15:0] det_typ, rnd_typ;
   logic [11:0] det_spd, rnd_spd;
   logic [3:0]  det_face, rnd_face;
   logic [39:0] det_sx, det_sy, rnd_sx, rnd_sy;
   logic        det_p1, det_p2, det_busy, rnd_p1, rnd_p2, rnd_busy;

   int          n_vec = 0, n_bad = 0, fc = 0;
   int          rise_t[8];
   logic [7:0]  prev_en;
   mstate_t     md, mr;
   logic [38:0] q_det[$], q_rnd[$];
   lane_vec_t   lane_tab[4];
   phase_t      ph[6];

   car_scheduler #(.RAND_SPAWN(0)) u_det (
      .FrameClk(FrameClk), .ResetN(ResetN), .RoundActive(RoundActive), .Level(Level),
      .P1HitVec(P1HitVec), .P2HitVec(P2HitVec), .SpawnEnable(det_en), .SlotType(det_typ),
      .LaneSpeed(det_spd), .LaneFaceLeft(det_face), .LaneSpawnX(det_sx), .LaneSpawnY(det_sy),
      .P1Hit(det_p1), .P2Hit(det_p2), .Busy(det_busy));

   car_scheduler u_rnd (
      .FrameClk(FrameClk), .ResetN(ResetN), .RoundActive(RoundActive), .Level(Level),
      .P1HitVec(P1HitVec), .P2HitVec(P2HitVec), .SpawnEnable(rnd_en), .SlotType(rnd_typ),
      .LaneSpeed(rnd_spd), .LaneFaceLeft(rnd_face), .LaneSpawnX(rnd_sx), .LaneSpawnY(rnd_sy),
      .P1Hit(rnd_p1), .P2Hit(rnd_p2), .Busy(rnd_busy));

   initial FrameClk = 1'b0;
   always #5 FrameClk = ~FrameClk;

   function automatic logic [10:0] life_of(input logic [2:0] spd);
      case (spd)
         3'd2: return 11'd688;
         3'd3: return 11'd460;
         3'd4: return 11'd344;
         3'd5: return 11'd276;
         3'd6: return 11'd230;
         3'd7: return 11'd198;
         default: return 11'd1376;
      endcase
   endfunction

   function automatic mstate_t mreset();
      mstate_t s;
      s = '0;
      s.lfsr = 16'hACE1;
      return s;
   endfunction

   function automatic mstate_t mstep(input mstate_t s, input logic ra, input logic [1:0] lv,
                                     input logic [7:0] h1, input logic [7:0] h2, input bit rnd);
      mstate_t n;
      int k, sum;
      bit done;
      n = s;
      n.lfsr = {s.lfsr[14:0], s.lfsr[15] ^ s.lfsr[13] ^ s.lfsr[12] ^ s.lfsr[10]};
      n.p1 = |(h1 & s.en);
      n.p2 = |(h2 & s.en);
      for (int l = 0; l < 4; l++)
         if (s.gap[l] != 8'd0) n.gap[l] = s.gap[l] - 8'd1;
      if (s.st != S_IDLE)
         for (int i = 0; i < 8; i++)
            if (s.en[i]) begin
               if (s.life[i] == 11'd1) begin
                  n.en[i] = 1'b0;
                  n.life[i] = '0;
               end else n.life[i] = s.life[i] - 11'd1;
            end
      if (s.st == S_RUN) begin
         n.ptr = s.ptr + 2'd1;
         done = 1'b0;
         if (s.gap[s.ptr] == 8'd0 && (!rnd || s.lfsr[0]))
            for (int j = 0; j < 2; j++) begin
               k = 2 * int'(s.ptr) + j;
               if (!done && !s.en[k]) begin
                  n.en[k]       = 1'b1;
                  n.typ[k]      = s.lfsr[2:1];
                  n.life[k]     = life_of(s.spd[s.ptr]);
                  n.gap[s.ptr]  = 8'(120 - 24 * int'(lv));
                  done          = 1'b1;
               end
            end
      end
      if (s.st == S_IDLE && ra)
         for (int l = 0; l < 4; l++) begin
            sum = 1 + int'(lv) + int'(s.lfsr[l+4]);
            n.spd[l] = (sum > 7) ? 3'd7 : 3'(sum);
         end
      case (s.st)
         S_IDLE:  if (ra) n.st = S_RUN;
         S_RUN:   if (!ra) n.st = S_DRAIN;
         default: if (ra) n.st = S_RUN; else if (s.en == 8'd0) n.st = S_IDLE;
      endcase
      return n;
   endfunction

   function automatic logic [38:0] mout(input mstate_t s);
      return {s.en, s.typ, s.spd, s.p1, s.p2, s.st != S_IDLE};
   endfunction

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
      n_vec++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", name, got, want);
      end
   endtask

   // One frame: predict, push, clock, pop and compare both instances.
   task automatic frame();
      md = mstep(md, RoundActive, Level, P1HitVec, P2HitVec, 1'b0);
      mr = mstep(mr, RoundActive, Level, P1HitVec, P2HitVec, 1'b1);
      q_det.push_back(mout(md));
      q_rnd.push_back(mout(mr));
      @(posedge FrameClk);
      #1;
      fc++;
      chk($sformatf("det_frame%0d", fc), 64'({det_en, det_typ, det_spd, det_p1, det_p2, det_busy}),
          64'(q_det.pop_front()));
      chk($sformatf("rnd_frame%0d", fc), 64'({rnd_en, rnd_typ, rnd_spd, rnd_p1, rnd_p2, rnd_busy}),
          64'(q_rnd.pop_front()));
      for (int k = 0; k < 8; k++)
         if (det_en[k] && !prev_en[k]) rise_t[k] = fc;
      prev_en = det_en;
   endtask

   initial begin
      int f0, n, len, lo, es, ezf;
      bit spawned;
      lane_tab[0] = '{0, 1'b0, 10'd51,  10'd96};
      lane_tab[1] = '{1, 1'b1, 10'd740, 10'd160};
      lane_tab[2] = '{2, 1'b0, 10'd51,  10'd224};
      lane_tab[3] = '{3, 1'b1, 10'd740, 10'd288};
      ph[0] = '{0, 1, 2'd3, 1, 40};
      ph[1] = '{0, 0, 2'd3, 1, 8};
      ph[2] = '{0, 1, 2'd2, 1, 30};
      ph[3] = '{1, 1, 2'd2, 1, 50};
      ph[4] = '{0, 0, 2'd2, 0, 12};
      ph[5] = '{0, 1, 2'd1, 1, 60};
      for (int k = 0; k < 8; k++) rise_t[k] = -1;
      prev_en = '0;
      ResetN = 1'b0; RoundActive = 1'b0; Level = 2'd0; P1HitVec = 8'h01; P2HitVec = 8'h00;
      md = mreset(); mr = mreset();
      repeat (2) @(posedge FrameClk);
      #1;
      chk("reset_det_out", 64'({det_en, det_typ, det_spd, det_p1, det_p2, det_busy}), 64'd0);
      chk("reset_rnd_out", 64'({rnd_en, rnd_typ, rnd_spd, rnd_p1, rnd_p2, rnd_busy}), 64'd0);
      chk("reset_lfsr", 64'(u_det.lfsr_q), 64'h ACE1);
      @(negedge FrameClk) ResetN = 1'b1;

      // Idle frames: nothing spawns, the LFSR still steps, masked hits stay low.
      repeat (10) frame();
      chk("idle_lfsr_det", 64'(u_det.lfsr_q), 64'(md.lfsr));
      chk("idle_lfsr_rnd", 64'(u_rnd.lfsr_q), 64'(mr.lfsr));

      for (int i = 0; i < 4; i++) begin
         chk($sformatf("face_l%0d", i), 64'(det_face[lane_tab[i].lane]), 64'(lane_tab[i].face));
         chk($sformatf("spx_l%0d", i), 64'(det_sx[lane_tab[i].lane*10 +: 10]), 64'(lane_tab[i].x));
         chk($sformatf("spy_l%0d", i), 64'(rnd_sy[lane_tab[i].lane*10 +: 10]), 64'(lane_tab[i].y));
      end

      // Level 0 deterministic round: one lane per frame, then the gap holds lane 0's second slot.
      RoundActive = 1'b1;
      frame();
      f0 = fc;
      for (int i = 0; i < 130; i++) begin
         frame();
         if (fc == f0 + 1) chk("hit_before_active", 64'(det_p1), 64'd0);
         if (fc == f0 + 2) chk("hit_after_active", 64'(det_p1), 64'd1);
      end
      for (int i = 0; i < 4; i++)
         chk($sformatf("l0_first_spawn_lane%0d", i), 64'(rise_t[2*i]), 64'(f0 + 1 + i));
      chk("l0_second_slot_gap", 64'(rise_t[1] - rise_t[0]), 64'd124);

      // Drain: no spawns, idle one frame after the last slot expires.
      RoundActive = 1'b0; P1HitVec = 8'h00;
      n = 0; ezf = -1; spawned = 1'b0;
      do begin
         logic [7:0] pe;
         pe = prev_en;
         frame();
         n++;
         if ((det_en & ~pe) != 8'd0) spawned = 1'b1;
         if (det_en == 8'd0 && ezf < 0) ezf = fc;
      end while (det_busy && n < 3000);
      chk("drain_ended", 64'(det_busy), 64'd0);
      chk("drain_no_spawn", 64'(spawned), 64'd0);
      chk("drain_idle_lag", 64'(fc - ezf), 64'd1);

      // Level 3: life length from the speed table, gap reload of 48, brief low before re-spawn.
      Level = 2'd3; RoundActive = 1'b1; P1HitVec = 8'h01;
      frame();
      n = 0;
      while (!det_en[0] && n < 20) begin frame(); n++; end
      chk("l3_slot0_rise", 64'(det_en[0]), 64'd1);
      es = rise_t[0];
      len = 0;
      while (det_en[0] && len < 2000) begin frame(); len++; end
      chk("l3_life_len", 64'(len), 64'(life_of(md.spd[0])));
      chk("l3_gap48", 64'(rise_t[1] - es), 64'd52);
      lo = 0;
      while (!det_en[0] && lo < 20) begin frame(); lo++; end
      chk("l3_respawn_low", 64'(lo >= 1 && lo <= 4), 64'd1);

      // Table of mixed phases, including an asynchronous reset in the middle of a round.
      for (int p = 0; p < 6; p++) begin
         if (ph[p].rst) begin
            #2 ResetN = 1'b0;
            #1;
            chk("arst_slots", 64'({det_en, rnd_en, det_busy, rnd_busy}), 64'd0);
            chk("arst_lfsr_det", 64'(u_det.lfsr_q), 64'hACE1);
            chk("arst_lfsr_rnd", 64'(u_rnd.lfsr_q), 64'hACE1);
            md = mreset(); mr = mreset(); prev_en = '0;
            @(negedge FrameClk) ResetN = 1'b1;
         end
         RoundActive = ph[p].ra;
         Level = ph[p].lv;
         for (int i = 0; i < ph[p].frames; i++) begin
            if (ph[p].rndhit) begin
               P1HitVec = 8'($urandom);
               P2HitVec = 8'($urandom);
            end else begin
               P1HitVec = 8'h00;
               P2HitVec = 8'h00;
            end
            frame();
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
